// File: rtl/cpu_pkg.sv
// Shared CPU encodings: PC-source selects, branch condition codes, flag-write bit indices.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_RSVD = 2'b10,
    PCSRC_B    = 2'b11
  } pc_src_e;

  typedef enum logic [2:0] {
    CC_NE  = 3'b000,
    CC_EQ  = 3'b001,
    CC_GT  = 3'b010,
    CC_LT  = 3'b011,
    CC_GE  = 3'b100,
    CC_LE  = 3'b101,
    CC_OV  = 3'b110,
    CC_UNC = 3'b111
  } ccc_e;

  // Bit positions inside the 3-bit flag-write enable from the decoder
  localparam int FW_Z = 2;
  localparam int FW_V = 1;
  localparam int FW_N = 0;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a condition code and Z/V/N flags to taken/not-taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       cond
);

  // Decode the condition code against the supplied flags
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cond = 1'b0;
    case (ccc_e'(ccc))
      CC_NE:  cond = !z;
      CC_EQ:  cond = z;
      CC_GT:  cond = !z && !n;
      CC_LT:  cond = n;
      CC_GE:  cond = z || (!z && !n);
      CC_LE:  cond = n || z;
      CC_OV:  cond = v;
      CC_UNC: cond = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// Next-PC and condition-flag stage: owns the PC, the Z/V/N flags and the sticky halt state.
module pc_flag_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic            hlt,
  input  logic [2:0]      fwr,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  input  logic [2:0]      ccc,
  input  logic [8:0]      imm9,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic            flag_z,
  output logic            flag_v,
  output logic            flag_n,
  output logic            branch_taken,
  output logic            halted
);

  flags_t          flags_q, flags_next;
  logic [PC_W-1:0] pc_q, pc_next;
  logic            halted_q, halted_next;
  logic            cond;
  logic [PC_W-1:0] b_offset;

  // Condition is always judged on the flags as they stood before this edge
  branch_cond u_branch_cond (
    .ccc  (ccc),
    .z    (flags_q.z),
    .v    (flags_q.v),
    .n    (flags_q.n),
    .cond (cond)
  );

  // Halfword offset sign-extended and scaled to bytes; wraps modulo 2^PC_W
  assign b_offset     = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
  assign pc_plus2     = pc_q + PC_W'(2);
  assign branch_taken = cond && ((pc_src == PCSRC_BR) || (pc_src == PCSRC_B));

  // Next-state selection: hold when stalled or halted, halt beats any PC change
  always_comb begin
    pc_next     = pc_q;
    flags_next  = flags_q;
    halted_next = halted_q;
    if (!stall && !halted_q) begin
      if (hlt) begin
        halted_next = 1'b1;
      end else begin
        case (pc_src_e'(pc_src))
          PCSRC_B:  pc_next = cond ? (pc_plus2 + b_offset) : pc_plus2;
          PCSRC_BR: pc_next = cond ? br_target : pc_plus2;
          default:  pc_next = pc_plus2;
        endcase
        if (fwr[FW_Z]) flags_next.z = alu_z;
        if (fwr[FW_V]) flags_next.v = alu_v;
        if (fwr[FW_N]) flags_next.n = alu_n;
      end
    end
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pc_q     <= RESET_VEC;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_next;
      flags_q  <= flags_next;
      halted_q <= halted_next;
    end
  end

  assign pc     = pc_q;
  assign flag_z = flags_q.z;
  assign flag_v = flags_q.v;
  assign flag_n = flags_q.n;
  assign halted = halted_q;

endmodule
